// File: rtl/clock_defs_pkg.sv
// Shared timekeeping constants and BCD digit helpers for the clock datapath.
package clock_defs;

  localparam int unsigned TIME_W      = 6;
  localparam int unsigned SEC_LIMIT   = 60;
  localparam int unsigned MIN_LIMIT   = 60;
  localparam int unsigned HOUR_LIMIT  = 24;
  localparam int unsigned BCD_DIGIT_W = 4;

  // Two-digit BCD range only; anything above 99 reads as 99.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_tens(input int unsigned v);
    return (v > 99) ? BCD_DIGIT_W'(9) : BCD_DIGIT_W'(v / 10);
  endfunction

  function automatic logic [BCD_DIGIT_W-1:0] bcd_ones(input int unsigned v);
    return (v > 99) ? BCD_DIGIT_W'(9) : BCD_DIGIT_W'(v % 10);
  endfunction

endpackage

// File: rtl/bin2bcd_reg.sv
// Registered binary -> two-digit BCD conversion with saturation above 99.
module bin2bcd_reg
  import clock_defs::*;
#(
  parameter int unsigned WIDTH     = TIME_W,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       bin,
  output logic [BCD_DIGIT_W-1:0] tens,
  output logic [BCD_DIGIT_W-1:0] ones
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= bcd_tens(RESET_VAL);
      ones <= bcd_ones(RESET_VAL);
    end else begin
      tens <= bcd_tens(32'(bin));
      ones <= bcd_ones(32'(bin));
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with preset range check, carry/borrow pulses and,
// under MOD_COUNTER_BCD_EN, a registered BCD view of the count.
module mod_counter
  import clock_defs::*;
#(
  parameter int unsigned WIDTH     = TIME_W,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_count,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_load_err
`ifdef MOD_COUNTER_BCD_EN
  ,
  output logic [BCD_DIGIT_W-1:0] o_tens,
  output logic [BCD_DIGIT_W-1:0] o_ones
`endif
);

  logic [WIDTH-1:0] max_val;

  // Wrapping subtract makes a limit of 0 yield the full 2^WIDTH-1 range.
  assign max_val = i_limit - WIDTH'(1);

  always_ff @(posedge i_clk) begin
    o_carry    <= 1'b0;
    o_borrow   <= 1'b0;
    o_load_err <= 1'b0;
    if (i_rst) begin
      o_count <= WIDTH'(RESET_VAL);
    end else if (i_load) begin
      if (i_load_val <= max_val) begin
        o_count <= i_load_val;
      end else begin
        o_count    <= '0;
        o_load_err <= 1'b1;
      end
    end else if (i_en) begin
      if (i_up) begin
        if (o_count >= max_val) begin
          o_count <= '0;
          o_carry <= 1'b1;
        end else begin
          o_count <= o_count + WIDTH'(1);
        end
      end else begin
        if (o_count == '0) begin
          o_count  <= max_val;
          o_borrow <= 1'b1;
        end else if (o_count > max_val) begin
          o_count <= max_val;
        end else begin
          o_count <= o_count - WIDTH'(1);
        end
      end
    end
  end

`ifdef MOD_COUNTER_BCD_EN
  bin2bcd_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_bcd (
    .clk  (i_clk),
    .rst  (i_rst),
    .bin  (o_count),
    .tens (o_tens),
    .ones (o_ones)
  );
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: reference model plus directed literal checks.
module tb_mod_counter;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] count;
  logic         carry, borrow, load_err;
`ifdef MOD_COUNTER_BCD_EN
  logic [3:0]   tens, ones;
`endif

  int total = 0;
  int bad   = 0;

  mod_counter #(
    .WIDTH     (W),
    .RESET_VAL (0)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_up       (up),
    .i_load     (load),
    .i_load_val (load_val),
    .i_limit    (limit),
    .o_count    (count),
    .o_carry    (carry),
    .o_borrow   (borrow),
    .o_load_err (load_err)
`ifdef MOD_COUNTER_BCD_EN
    ,
    .o_tens     (tens),
    .o_ones     (ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: value semantics over the modulus N as an integer.
  int m_count = 0;
  int m_carry = 0, m_borrow = 0, m_err = 0;
  int m_tens = 0, m_ones = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    int n, prev;
    prev     = m_count;
    n        = (limit == 0) ? (1 << W) : int'(limit);
    m_carry  = 0;
    m_borrow = 0;
    m_err    = 0;
    if (rst) begin
      m_count  = 0;
      model_ok = 1'b1;
    end else if (load) begin
      if (int'(load_val) < n) m_count = int'(load_val);
      else begin
        m_count = 0;
        m_err   = 1;
      end
    end else if (en && up) begin
      if (prev + 1 >= n) begin
        m_count = 0;
        m_carry = 1;
      end else m_count = prev + 1;
    end else if (en) begin
      if (prev == 0) begin
        m_count  = n - 1;
        m_borrow = 1;
      end else if (prev >= n) m_count = n - 1;
      else m_count = prev - 1;
    end
    if (rst) begin
      m_tens = 0;
      m_ones = 0;
    end else begin
      m_tens = (prev > 99) ? 9 : prev / 10;
      m_ones = (prev > 99) ? 9 : prev % 10;
    end
    #1;
    if (model_ok) begin
      check("model_count",  count,    m_count);
      check("model_carry",  carry,    m_carry);
      check("model_borrow", borrow,   m_borrow);
      check("model_lderr",  load_err, m_err);
`ifdef MOD_COUNTER_BCD_EN
      check("model_tens",   tens,     m_tens);
      check("model_ones",   ones,     m_ones);
`endif
    end
  end

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input int lim);
    logic [31:0] lv_v, lim_v;
    lv_v     = lv;
    lim_v    = lim;
    rst      = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv_v[W-1:0];
    limit    = lim_v[W-1:0];
    @(negedge clk);
  endtask

  initial begin
    int lims [5];
    lims = '{0, 1, 7, 24, 60};

    drive(1, 0, 1, 0, 0, 60);
    drive(1, 0, 1, 0, 0, 60);
    check("rst_count",  count,    0);
    check("rst_carry",  carry,    0);
    check("rst_borrow", borrow,   0);
    check("rst_lderr",  load_err, 0);
`ifdef MOD_COUNTER_BCD_EN
    check("rst_tens", tens, 0);
    check("rst_ones", ones, 0);
`endif

    for (int i = 1; i < 60; i++) drive(0, 1, 1, 0, 0, 60);
    check("up_59",        count, 59);
    check("up_59_carry",  carry, 0);
    drive(0, 1, 1, 0, 0, 60);
    check("wrap_up_cnt",  count, 0);
    check("wrap_up_cy",   carry, 1);
    drive(0, 0, 1, 0, 0, 60);
    check("carry_1cyc",   carry, 0);

    drive(0, 0, 0, 1, 0, 24);
    drive(0, 1, 0, 0, 0, 24);
    check("wrap_dn_cnt",  count, 23);
    check("wrap_dn_bw",   borrow, 1);
    drive(0, 1, 0, 0, 0, 24);
    check("dn_22",        count, 22);
    check("dn_22_bw",     borrow, 0);

    drive(0, 0, 1, 1, 45, 60);
    check("load45",       count, 45);
    check("load45_err",   load_err, 0);
    drive(0, 0, 1, 1, 60, 60);
    check("load60",       count, 0);
    check("load60_err",   load_err, 1);
    drive(0, 0, 1, 1, 59, 60);
    drive(0, 1, 1, 1, 10, 60);
    check("load_en_cnt",  count, 10);
    check("load_en_cy",   carry, 0);

    drive(0, 0, 1, 1, 50, 60);
    drive(0, 0, 1, 0, 0, 24);
    check("hold_oor",     count, 50);
    drive(0, 1, 1, 0, 0, 24);
    check("shrink_up",    count, 0);
    check("shrink_up_cy", carry, 1);
    drive(0, 0, 1, 1, 50, 60);
    drive(0, 1, 0, 0, 0, 24);
    check("shrink_dn",    count, 23);
    check("shrink_dn_bw", borrow, 0);

    drive(0, 0, 1, 1, 63, 0);
    check("lim0_load63",  load_err, 0);
    drive(0, 1, 1, 0, 0, 0);
    check("lim0_up",      count, 0);
    check("lim0_up_cy",   carry, 1);
    drive(0, 1, 0, 0, 0, 0);
    check("lim0_dn",      count, 63);
    check("lim0_dn_bw",   borrow, 1);

    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    check("n1_up",        count, 0);
    check("n1_up_cy",     carry, 1);
    drive(0, 1, 0, 0, 0, 1);
    check("n1_dn",        count, 0);
    check("n1_dn_bw",     borrow, 1);

    drive(0, 0, 1, 1, 59, 60);
    drive(1, 1, 1, 1, 5, 60);
    check("rst_mid_cnt",  count, 0);
    check("rst_mid_cy",   carry, 0);

`ifdef MOD_COUNTER_BCD_EN
    drive(0, 0, 1, 1, 36, 60);
    drive(0, 1, 1, 0, 0, 60);
    check("bcd_lag_tens", tens, 3);
    check("bcd_lag_ones", ones, 6);
    drive(0, 0, 1, 0, 0, 60);
    check("bcd37_tens",   tens, 3);
    check("bcd37_ones",   ones, 7);
    drive(1, 1, 1, 0, 0, 60);
    check("bcd_rst_tens", tens, 0);
    check("bcd_rst_ones", ones, 0);
`endif

    for (int i = 0; i < 300; i++)
      drive(($urandom % 25) == 0, $urandom % 2, $urandom % 2, ($urandom % 6) == 0,
            int'($urandom % 64), lims[$urandom % 5]);

    drive(0, 0, 1, 0, 0, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
